// File: rtl/aes_block_assembler.sv
// Packs NBYTES byte_valid pulses into one block (first byte in the MSBs); block_valid rises 1 clk after the last byte.
// Back-pressure: one holding register; a block completing while it is still held and not being taken is dropped and sets overflow.
module aes_block_assembler #(
    parameter int NBYTES = 16,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  clear,
    output logic [8*NBYTES-1:0]   block_out,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic [CNT_W-1:0]      byte_count,
    output logic                  overflow
);

    localparam int ACC_W = (NBYTES - 1) * 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [8*NBYTES-1:0] out_nxt;
    logic                ovf_nxt;
    logic                complete;

    // clear takes priority over a coincident byte, even a completing one
    assign complete    = byte_valid && !clear && (byte_count == LAST);
    assign block_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            acc        <= '0;
            byte_count <= '0;
            block_out  <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            byte_count <= cnt_nxt;
            block_out  <= out_nxt;
            overflow   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = byte_count;
        out_nxt   = block_out;
        ovf_nxt   = overflow;

        if (clear) begin
            acc_nxt = '0;
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (byte_valid) begin
            if (byte_count == LAST) begin
                // acc is left as-is; the next block overwrites it byte by byte
                cnt_nxt = '0;
            end else begin
                acc_nxt = (acc << 8) | ACC_W'(byte_in);
                cnt_nxt = byte_count + 1'b1;
            end
        end

        case (state)
            EMPTY: begin
                if (complete) begin
                    out_nxt   = {acc, byte_in};
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (block_ready) begin
                        out_nxt = {acc, byte_in};
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end else if (block_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_aes_block_assembler.sv
// Directed and randomized checks of aes_block_assembler against hand-computed blocks and a scoreboard.
module tb_aes_block_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   byte_in = '0;
    logic         byte_valid = 1'b0;
    logic         clear = 1'b0;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic [3:0]   byte_count;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    aes_block_assembler #(.NBYTES(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .clear       (clear),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .byte_count  (byte_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] blk(input logic [7:0] base);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], 8'(base + 8'(i))};
        return r;
    endfunction

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'(base + 8'(i));
            tick();
        end
        byte_valid = 1'b0;
    endtask

    // Scoreboard state for the randomized phase
    logic [127:0] sb_q[$];
    logic [127:0] m_cur;
    int           m_cnt;
    logic         m_full;
    logic         m_ovf;
    int           n_sent;
    int           n_got;

    task automatic cyc(input logic v, input logic [7:0] b, input logic force_rdy);
        logic [127:0] exp_blk;
        byte_valid  = v;
        byte_in     = b;
        block_ready = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
        if (block_valid && block_ready) begin
            exp_blk = (sb_q.size() > 0) ? sb_q.pop_front() : 128'hx;
            check("rand_deliver", block_out, exp_blk);
            n_got++;
        end
        if (v) begin
            m_cur = {m_cur[119:0], b};
            m_cnt++;
        end
        if (v && m_cnt == 16) begin
            m_cnt = 0;
            n_sent++;
            if (!m_full || block_ready) begin
                sb_q.push_back(m_cur);
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_full && block_ready) begin
            m_full = 1'b0;
        end
        tick();
        check("rand_valid", block_valid, m_full);
        check("rand_ovf", overflow, m_ovf);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out", block_out, 0);
        check("rst_valid", block_valid, 0);
        check("rst_cnt", byte_count, 0);
        check("rst_ovf", overflow, 0);
        tick();
        rst = 1'b1;
        tick();

        // 1: single block, consumer always ready
        block_ready = 1'b1;
        send_bytes(8'h00, 15);
        check("t1_cnt15", byte_count, 4'd15);
        check("t1_nvalid", block_valid, 0);
        send_bytes(8'h0F, 1);
        check("t1_valid", block_valid, 1);
        check("t1_out", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_cnt0", byte_count, 0);
        tick();
        check("t1_drop", block_valid, 0);
        check("t1_keep", block_out, 128'h000102030405060708090A0B0C0D0E0F);

        // 2: overflow while consumer stalled
        block_ready = 1'b0;
        send_bytes(8'h10, 16);
        check("t2_a_valid", block_valid, 1);
        check("t2_a_out", block_out, blk(8'h10));
        send_bytes(8'h20, 16);
        check("t2_ovf", overflow, 1);
        check("t2_cnt", byte_count, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t2_hold", block_out, blk(8'h10));
        check("t2_hold_v", block_valid, 1);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        check("t2_drain", block_valid, 0);
        check("t2_ovf_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // 3: back-to-back handoff on the completing byte
        send_bytes(8'h30, 16);
        check("t3_c", block_out, blk(8'h30));
        send_bytes(8'h40, 15);
        check("t3_hold", block_out, blk(8'h30));
        block_ready = 1'b1;
        send_bytes(8'h4F, 1);
        check("t3_valid", block_valid, 1);
        check("t3_out", block_out, blk(8'h40));
        check("t3_ovf", overflow, 0);
        block_ready = 1'b0;
        tick();
        check("t3_stay", block_valid, 1);
        block_ready = 1'b1;
        tick();
        check("t3_drain", block_valid, 0);

        // 4: clear drops a partial block and a coincident byte
        send_bytes(8'h00, 7);
        check("t4_cnt7", byte_count, 4'd7);
        clear = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'h77;
        tick();
        clear = 1'b0;
        byte_valid = 1'b0;
        check("t4_cnt0", byte_count, 0);
        send_bytes(8'hA0, 16);
        check("t4_out", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        tick();
        send_bytes(8'hB0, 15);
        clear = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hBF;
        tick();
        clear = 1'b0;
        byte_valid = 1'b0;
        check("t4_clr_last_v", block_valid, 0);
        check("t4_clr_last_c", byte_count, 0);

        // 5: asynchronous reset mid-block with a pending block
        block_ready = 1'b0;
        send_bytes(8'h50, 16);
        send_bytes(8'h00, 9);
        check("t5_cnt9", byte_count, 4'd9);
        #3 rst = 1'b0;
        #1;
        check("t5_out", block_out, 0);
        check("t5_valid", block_valid, 0);
        check("t5_cnt", byte_count, 0);
        tick();
        rst = 1'b1;
        tick();
        send_bytes(8'h60, 16);
        check("t5_fresh", block_out, blk(8'h60));
        block_ready = 1'b1;
        tick();
        check("t5_drain", block_valid, 0);

        // 6: random gaps and ready, scoreboarded
        sb_q.delete();
        m_cur = '0; m_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
        n_sent = 0; n_got = 0;
        for (int b = 0; b < 200; b++) begin
            for (int k = 0; k < 16; k++) begin
                int gap;
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : 0;
                for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, 1'b0);
                cyc(1'b1, 8'($urandom), 1'b0);
            end
        end
        for (int g = 0; g < 3; g++) cyc(1'b0, 8'h00, 1'b1);
        check("rand_empty", 128'(sb_q.size()), 0);
        check("rand_sent", 128'(n_sent), 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
